// File: rtl/xlr8_boot_restore_ctl.sv
// xlr8_boot_restore_ctl: restores AVR pmem from UFM flash after reset, optional CRC check under XLR8_BOOT_CRC_EN
module xlr8_boot_restore_ctl #(
  parameter int PMEM_WORDS = 8192,
  parameter int PMEM_AW    = 13,
  parameter int FLASH_AW   = 17,
  parameter int FLASH_BASE = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                restore_en,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic                flash_read,
  input  logic                flash_waitrequest,
  input  logic [31:0]         flash_readdata,
  input  logic                flash_readdatavalid,
  output logic                pmem_we,
  output logic [PMEM_AW-1:0]  pmem_addr,
  output logic [15:0]         pmem_wdata,
  output logic                core_rst_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         crc_out
);
  localparam int IW = PMEM_AW - 1;
  localparam int TW = $clog2(TIMEOUT + 2);
`ifdef XLR8_BOOT_CRC_EN
  typedef enum logic [3:0] {IDLE, REQ, WAIT, WR_LO, WR_HI, CRC_REQ, CRC_WAIT, DONE, ERR} state_t;
  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = (r << 1) ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  logic [15:0] crc_q, crc_d;
  assign crc_out = crc_q;
`else
  typedef enum logic [3:0] {IDLE, REQ, WAIT, WR_LO, WR_HI, DONE, ERR} state_t;
  assign crc_out = 16'h0000;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic flash_read_q, flash_read_d, pmem_we_q, pmem_we_d;
  logic [FLASH_AW-1:0] flash_addr_q, flash_addr_d;
  logic [PMEM_AW-1:0] pmem_addr_q, pmem_addr_d;
  logic [15:0] pmem_wdata_q, pmem_wdata_d;
  logic hold_q, hold_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic last, expired;
  assign last    = {idx_q, 1'b1} == PMEM_AW'(PMEM_WORDS - 1);
  assign expired = cnt_q == TW'(TIMEOUT);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef XLR8_BOOT_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = restore_en ? REQ : DONE;
        idx_d   = '0;
`ifdef XLR8_BOOT_CRC_EN
        crc_d   = 16'hFFFF;
`endif
      end
      REQ: if (!flash_waitrequest) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (flash_readdatavalid) begin
        data_d  = flash_readdata;
        state_d = WR_LO;
      end else if (expired) state_d = ERR;
      else cnt_d = cnt_q + TW'(1);
      WR_LO: state_d = WR_HI;
`ifdef XLR8_BOOT_CRC_EN
      WR_HI: if (last) state_d = CRC_REQ;
      else begin
        idx_d   = idx_q + IW'(1);
        state_d = REQ;
      end
      CRC_REQ: if (!flash_waitrequest) begin
        state_d = CRC_WAIT;
        cnt_d   = '0;
      end
      CRC_WAIT: if (flash_readdatavalid) state_d = (flash_readdata[15:0] == crc_q) ? DONE : ERR;
      else if (expired) state_d = ERR;
      else cnt_d = cnt_q + TW'(1);
`else
      WR_HI: if (last) state_d = DONE;
      else begin
        idx_d   = idx_q + IW'(1);
        state_d = REQ;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef XLR8_BOOT_CRC_EN
    flash_read_d = state_d == REQ || state_d == CRC_REQ;
    flash_addr_d = !flash_read_d ? flash_addr_q :
                   state_d == CRC_REQ ? FLASH_AW'(FLASH_BASE + PMEM_WORDS / 2) :
                   FLASH_AW'(FLASH_BASE) + FLASH_AW'(idx_d);
`else
    flash_read_d = state_d == REQ;
    flash_addr_d = flash_read_d ? FLASH_AW'(FLASH_BASE) + FLASH_AW'(idx_d) : flash_addr_q;
`endif
    pmem_we_d    = state_d == WR_LO || state_d == WR_HI;
    pmem_addr_d  = pmem_we_d ? {idx_d, state_d == WR_HI} : pmem_addr_q;
    pmem_wdata_d = !pmem_we_d ? pmem_wdata_q : state_d == WR_HI ? data_d[31:16] : data_d[15:0];
`ifdef XLR8_BOOT_CRC_EN
    crc_d        = pmem_we_d ? crc16(crc_q, pmem_wdata_d) : crc_d;
`endif
    busy_d = !(state_d == IDLE || state_d == DONE || state_d == ERR);
    done_d = state_d == DONE;
    err_d  = state_d == ERR;
    hold_d = state_d != DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      flash_read_q <= 1'b0;
      flash_addr_q <= '0;
      pmem_we_q    <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      hold_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef XLR8_BOOT_CRC_EN
      crc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      flash_read_q <= flash_read_d;
      flash_addr_q <= flash_addr_d;
      pmem_we_q    <= pmem_we_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef XLR8_BOOT_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end
  assign flash_read    = flash_read_q;
  assign flash_addr    = flash_addr_q;
  assign pmem_we       = pmem_we_q;
  assign pmem_addr     = pmem_addr_q;
  assign pmem_wdata    = pmem_wdata_q;
  assign core_rst_hold = hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_xlr8_boot_restore_ctl.sv
// tb_xlr8_boot_restore_ctl: directed self-checking bench for the boot restore sequencer
module tb_xlr8_boot_restore_ctl;
  localparam int PW = 8, AW = 3, FAW = 17, FB = 16, TO = 10;
`ifdef XLR8_BOOT_CRC_EN
  localparam int CX = 2;
`else
  localparam int CX = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, restore_en = 1'b1;
  logic [FAW-1:0] flash_addr;
  logic flash_read, flash_waitrequest, flash_readdatavalid;
  logic [31:0] flash_readdata;
  logic pmem_we, core_rst_hold, busy, done, err;
  logic [AW-1:0] pmem_addr;
  logic [15:0] pmem_wdata, crc_out;
  logic rdv_m = 1'b0, rdv_force = 1'b0, no_resp = 1'b0, clr = 1'b0, flip = 1'b0;
  logic [31:0] rdata = 32'h0;
  int stall_cfg = 0, stall_used = 0, n_wr = 0;
  logic [AW-1:0] wa [16];
  logic [15:0] wd [16];
  int checks = 0, errors = 0;
  xlr8_boot_restore_ctl #(.PMEM_WORDS(PW), .PMEM_AW(AW), .FLASH_AW(FAW), .FLASH_BASE(FB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .restore_en(restore_en),
    .flash_addr(flash_addr), .flash_read(flash_read), .flash_waitrequest(flash_waitrequest),
    .flash_readdata(flash_readdata), .flash_readdatavalid(flash_readdatavalid),
    .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .core_rst_hold(core_rst_hold), .busy(busy), .done(done), .err(err), .crc_out(crc_out));
  always #5 clk = ~clk;
  function automatic logic [15:0] exp_w(input int i);
    return 16'h1234 + 16'(i) * 16'h0101;
  endfunction
`ifdef XLR8_BOOT_CRC_EN
  function automatic logic [15:0] crc_good();
    logic [15:0] r;
    r = 16'hFFFF;
    for (int w = 0; w < PW; w++)
      for (int b = 15; b >= 0; b--) begin
        logic [15:0] d;
        d = exp_w(w);
        r = (r << 1) ^ ((r[15] ^ d[b]) ? 16'h1021 : 16'h0000);
      end
    return r;
  endfunction
`endif
  function automatic logic [31:0] img(input logic [FAW-1:0] a);
    int k;
    k = int'(a) - FB;
    if (k >= 0 && k < PW / 2) return {exp_w(2 * k + 1), exp_w(2 * k)};
`ifdef XLR8_BOOT_CRC_EN
    if (k == PW / 2) return {16'h0000, crc_good() ^ {15'b0, flip}};
`endif
    return 32'hDEAD_BEEF;
  endfunction
  assign flash_waitrequest   = flash_read && flash_addr == FAW'(FB + 1) && stall_used < stall_cfg;
  assign flash_readdatavalid = rdv_m | rdv_force;
  assign flash_readdata      = rdata;
  always @(posedge clk) begin
    rdv_m <= flash_read && !flash_waitrequest && !no_resp;
    rdata <= img(flash_addr);
    if (clr) begin
      stall_used <= 0;
      n_wr <= 0;
    end else begin
      if (flash_waitrequest) stall_used <= stall_used + 1;
      if (pmem_we && n_wr < 16) begin
        wa[n_wr] <= pmem_addr;
        wd[n_wr] <= pmem_wdata;
        n_wr <= n_wr + 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask
  task automatic pulse_start(input logic en);
    restore_en = en;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic check_image(input string tag);
    chk({tag, "_nwr"}, 32'(n_wr), PW);
    for (int i = 0; i < PW; i++) begin
      chk({tag, "_addr"}, 32'(wa[i]), 32'(i));
      chk({tag, "_data"}, 32'(wd[i]), 32'(exp_w(i)));
    end
  endtask
  initial begin
    cyc(5);
    chk("rst_ctl", {flash_read, pmem_we, busy, done, err, core_rst_hold}, 6'b000001);
    chk("rst_faddr", 32'(flash_addr), 0);
    chk("rst_pmem", {pmem_addr, pmem_wdata}, 0);
    chk("rst_crc", 32'(crc_out), 0);
    rst = 1'b0;
    clear();
    pulse_start(1'b1);
    chk("t1_req", {busy, flash_read, 15'(flash_addr)}, {2'b11, 15'(FB)});
    cyc(2);
    chk("t1_wr_lo", {pmem_we, 13'(pmem_addr), pmem_wdata}, {1'b1, 13'd0, 16'h1234});
    cyc(1);
    chk("t1_wr_hi", {pmem_we, 13'(pmem_addr), pmem_wdata}, {1'b1, 13'd1, 16'h1335});
    cyc(12 + CX);
    chk("t1_not_yet", {done, core_rst_hold, busy}, 3'b011);
    cyc(1);
    chk("t1_done", {done, core_rst_hold, busy, err}, 4'b1000);
    check_image("t1");
`ifdef XLR8_BOOT_CRC_EN
    chk("t1_crc", 32'(crc_out), 32'(crc_good()));
`else
    chk("t1_crc", 32'(crc_out), 0);
`endif
    stall_cfg = 3;
    clear();
    pulse_start(1'b1);
    cyc(4);
    for (int k = 0; k < 3; k++) begin
      chk("t2_stall", {flash_waitrequest, flash_read, 15'(flash_addr)}, {2'b11, 15'(FB + 1)});
      cyc(1);
    end
    chk("t2_release", {flash_waitrequest, flash_read, 15'(flash_addr)}, {2'b01, 15'(FB + 1)});
    cyc(11 + CX);
    chk("t2_not_yet", 32'(done), 0);
    cyc(1);
    chk("t2_done", {done, core_rst_hold}, 2'b10);
    check_image("t2");
    stall_cfg = 0;
    no_resp = 1'b1;
    clear();
    pulse_start(1'b1);
    cyc(TO + 1);
    chk("t3_waiting", {busy, err, core_rst_hold}, 3'b101);
    cyc(1);
    chk("t3_err", {busy, err, done, core_rst_hold}, 4'b0101);
    chk("t3_nwr", 32'(n_wr), 0);
    no_resp = 1'b0;
    clear();
    pulse_start(1'b0);
    chk("t4_done", {done, err, busy, core_rst_hold, flash_read}, 5'b10000);
    cyc(3);
    chk("t4_quiet", {32'(n_wr), 1'b0, done}, {32'd0, 1'b0, 1'b1});
    clear();
    pulse_start(1'b1);
    cyc(3);
    chk("t5_in_wr_hi", {pmem_we, 13'(pmem_addr)}, {1'b1, 13'd1});
    rst = 1'b1;
    rdv_force = 1'b1;
    cyc(1);
    chk("t5_reset", {flash_read, pmem_we, busy, done, err, core_rst_hold}, 6'b000001);
    rst = 1'b0;
    cyc(2);
    rdv_force = 1'b0;
    cyc(3);
    chk("t5_idle", {flash_read, pmem_we, busy, done, err, core_rst_hold}, 6'b000001);
    chk("t5_nwr", 32'(n_wr), 2);
`ifdef XLR8_BOOT_CRC_EN
    flip = 1'b1;
    clear();
    pulse_start(1'b1);
    cyc(18);
    chk("t6_bad_crc", {err, done, busy, core_rst_hold}, 4'b1001);
    chk("t6_crc", 32'(crc_out), 32'(crc_good()));
    flip = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
